uart_echo_responder: RTL and testbench
======================================

# uart_echo_responder

Byte-level responder at the far end of the UART link: consumes bytes delivered by the UART receiver (`rx_msg`/`rx_parity`/`rx_complete`) and transmits each accepted byte back out on its own serial `tx` line. Each byte is parity-checked on entry and buffered in a small FIFO. Each byte is then re-framed as start, 8 data bits LSB-first, parity and stop. It closes the loop for link bring-up and soak testing on the 3.125 MHz clock domain.

## Interface
- `CLKS_PER_BIT`, 27: clocks per serial bit (3.125 MHz / 27 ≈ 115200 baud); must be ≥ 2.
- `FIFO_DEPTH`, 4: byte buffer entries; power of two, ≥ 2.

- `clk_3125`  in  1  sole clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `parity_type`  in  1  0 = even, 1 = odd; used for both the check and the generated parity.
- `rx_msg`  in  8  received data byte, valid while `rx_complete` is high.
- `rx_parity`  in  1  received parity bit, valid with `rx_msg`.
- `rx_complete`  in  1  receiver byte-done level; may stay high for any number of cycles.
- `tx`  out  1  serial output, idle high.
- `tx_done`  out  1  one-cycle pulse on the last cycle of each stop bit.
- `fifo_empty`  out  1  FIFO holds no bytes.
- `fifo_full`  out  1  FIFO holds `FIFO_DEPTH` bytes.
- `overflow_cnt`  out  8  bytes dropped because the FIFO was full; saturates at 255.
- `parity_err_cnt`  out  8  bytes dropped on parity mismatch; saturates at 255. Tied to 0 when the parity check is compiled out.

## Operation
- **Capture:**
  - Register `rx_complete` each cycle. A capture event is a cycle where `rx_complete` is 1 and its registered copy is 0.
  - One capture event produces exactly one candidate byte.
- **Parity check:** the candidate fails when `^rx_msg ^ rx_parity ^ parity_type` = 1.
- **Push rules:**
  - A candidate that fails the parity check is dropped, never pushed.
  - A passing candidate is pushed when the FIFO is not full, or when a pop occurs on the same edge.
  - Otherwise the candidate is dropped and `overflow_cnt` increments.
- **TX state machine:** states IDLE, START, DATA, PARITY, STOP.
  - IDLE, FIFO not empty → pop the head byte, latch `parity_type`, go to START.
  - START drives `tx`=0.
  - DATA drives bits 0..7 in order.
  - PARITY drives `^byte ^ latched_parity_type`.
  - STOP drives `tx`=1.
  - Each state lasts `CLKS_PER_BIT` cycles, counted by a bit-cycle counter. A separate bit index counts 0..7 within DATA.
  - STOP → IDLE.
- **Ordering:** bytes are transmitted strictly in capture order. A change to `parity_type` mid-frame does not affect the frame in flight.
- **Reset values:**
  - `tx`=1, `tx_done`=0.
  - `fifo_empty`=1, `fifo_full`=0.
  - Both counters 0, state IDLE, FIFO pointers 0.
  - Registered `rx_complete` = 0.

## Timing
- **Capture to push:** when `rx_complete` is first sampled high at edge k, the push completes at edge k, so `fifo_empty` falls after edge k.
- **Start of frame:** IDLE pops at edge k+1 and `tx` falls after edge k+1. Latency from capture to start bit is 2 cycles.
- **Frame length:** exactly 11×`CLKS_PER_BIT` cycles (297 at the default).
- **Back-to-back frames:** with more bytes queued, the next START follows after one IDLE cycle. The inter-frame gap is `CLKS_PER_BIT`+1 high cycles.
- **`tx_done`:** high only in the final STOP cycle.
- **Simultaneous push and pop while full:** both occur; the count is unchanged; nothing is dropped.
- **FIFO pointers:** wrap modulo `FIFO_DEPTH`. Full and empty are distinguished by an extra pointer bit.
- **Reset asserted mid-frame:** at the next edge, `tx` returns to 1 and the frame is abandoned without `tx_done`. The FIFO is flushed and both counters clear.
- **`rx_complete` high during reset:** no capture occurs. If it is still high after reset deasserts, it triggers one capture, because the registered copy resets to 0.

## Configuration
- `UART_ECHO_PARITY_CHECK_EN`
  - Defined: the parity check is active; failing bytes are dropped and `parity_err_cnt` increments, saturating.
  - Undefined: every captured byte is eligible for push regardless of `rx_parity`, and `parity_err_cnt` is constant 0. Generated TX parity is unaffected either way.

## Test plan
- **Single byte, even parity:** `rx_msg`=0x50, `rx_parity`=0, `parity_type`=0, one `rx_complete` pulse. Required: `tx` low 2 cycles after capture; frame bits 0,0,0,0,1,0,1,0, parity 0, stop 1; each bit 27 cycles; `tx_done` pulse at cycle 297 of the frame.
- **Odd parity:** 0x74 with `parity_type`=1 and `rx_parity`=1. Required: byte accepted; echoed frame parity bit = 1.
- **Parity error:** 0x41 with `rx_parity`=1 and `parity_type`=0.
  - Macro defined: no frame transmitted, `parity_err_cnt`=1.
  - Macro undefined: byte echoed with parity bit 0.
- **Overflow:** six `rx_complete` pulses every 2 cycles (0x01..0x06), default depth. Required: byte 1 starts at once, bytes 2–5 fill the FIFO (`fifo_full`=1), byte 6 dropped, `overflow_cnt`=1; frames 0x01..0x05 echoed in order.
- **Held strobe:** `rx_complete` high for 10 cycles. Required: exactly one byte echoed.
- **Reset mid-frame:** assert `reset` during DATA bit 3 with 2 bytes queued. Required: `tx`=1 on the next edge; no `tx_done`; `fifo_empty`=1 and counters 0 after the edge; no frame starts after reset release.

Source files
------------

// File: rtl/uart_echo_responder_if.sv
// Byte-delivery bundle from the UART receiver into the echo responder.
// master = receiver side (drives the byte), slave = responder side.
interface uart_echo_responder_if;
  logic [7:0] rx_msg;
  logic       rx_parity;
  logic       rx_complete;

  modport master (output rx_msg, rx_parity, rx_complete);
  modport slave  (input  rx_msg, rx_parity, rx_complete);
endinterface

// File: rtl/uart_echo_responder.sv
// Echoes each received byte on tx as start/8 data LSB-first/parity/stop; `UART_ECHO_PARITY_CHECK_EN filters bad-parity input.
// Latency: capture edge to start bit 2 cycles; frame 11*CLKS_PER_BIT cycles, one idle cycle between queued frames.
// Backpressure: none upstream; a byte arriving with the FIFO full and no same-edge pop is dropped and counted.
module uart_echo_responder #(
  parameter int CLKS_PER_BIT = 27,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                 clk_3125,
  input  logic                 reset,
  input  logic                 parity_type,
  uart_echo_responder_if.slave rx,
  output logic                 tx,
  output logic                 tx_done,
  output logic                 fifo_empty,
  output logic                 fifo_full,
  output logic [7:0]           overflow_cnt,
  output logic [7:0]           parity_err_cnt
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] bit_cnt_q, bit_cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    byte_q, byte_d;
  logic          par_type_q, par_type_d;

  logic          rx_complete_q;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW:0]   wr_ptr_q, rd_ptr_q;
  logic [7:0]    ovf_q;
  logic          capture, parity_ok, push, pop, bit_end;

  assign capture = rx.rx_complete & ~rx_complete_q;

`ifdef UART_ECHO_PARITY_CHECK_EN
  logic [7:0] perr_q;

  assign parity_ok      = ~(^rx.rx_msg ^ rx.rx_parity ^ parity_type);
  assign parity_err_cnt = perr_q;

  always_ff @(posedge clk_3125) begin
    if (reset) begin
      perr_q <= '0;
    end else if (capture && !parity_ok && perr_q != 8'hFF) begin
      perr_q <= perr_q + 8'd1;
    end
  end
`else
  logic unused_rx_parity;

  assign unused_rx_parity = rx.rx_parity;
  assign parity_ok        = 1'b1;
  assign parity_err_cnt   = '0;
`endif

  // Extra MSB on the pointers separates full from empty when the indices match.
  assign fifo_empty   = (wr_ptr_q == rd_ptr_q);
  assign fifo_full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop          = (state_q == S_IDLE) && !fifo_empty;
  assign push         = capture && parity_ok && (!fifo_full || pop);
  assign overflow_cnt = ovf_q;

  always_ff @(posedge clk_3125) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= rx.rx_msg;
    end
  end

  always_ff @(posedge clk_3125) begin
    if (reset) begin
      rx_complete_q <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      ovf_q         <= '0;
    end else begin
      rx_complete_q <= rx.rx_complete;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (capture && parity_ok && !push && ovf_q != 8'hFF) begin
        ovf_q <= ovf_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk_3125) begin
    if (reset) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      bit_idx_q  <= '0;
      byte_q     <= '0;
      par_type_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      bit_idx_q  <= bit_idx_d;
      byte_q     <= byte_d;
      par_type_q <= par_type_d;
    end
  end

  assign bit_end = (bit_cnt_q == BIT_LAST);

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    bit_idx_d  = bit_idx_q;
    byte_d     = byte_q;
    par_type_d = par_type_q;
    tx         = 1'b1;
    tx_done    = 1'b0;
    if (state_q != S_IDLE) begin
      bit_cnt_d = bit_end ? '0 : bit_cnt_q + 1'b1;
    end
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          byte_d     = mem_q[rd_ptr_q[AW-1:0]];
          par_type_d = parity_type;
          bit_cnt_d  = '0;
          bit_idx_d  = '0;
          state_d    = S_START;
        end
      end
      S_START: begin
        tx = 1'b0;
        if (bit_end) state_d = S_DATA;
      end
      S_DATA: begin
        tx = byte_q[bit_idx_q];
        if (bit_end) begin
          bit_idx_d = bit_idx_q + 1'b1;
          if (bit_idx_q == 3'd7) state_d = S_PARITY;
        end
      end
      S_PARITY: begin
        tx = ^byte_q ^ par_type_q;
        if (bit_end) state_d = S_STOP;
      end
      S_STOP: begin
        tx_done = bit_end;
        if (bit_end) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_uart_echo_responder.sv
// Directed bench for uart_echo_responder at the default 27 clocks/bit, depth 4.
module tb_uart_echo_responder;
  localparam int CPB   = 27;
  localparam int FRAME = 11 * CPB;

  logic       clk_3125 = 1'b0;
  logic       reset;
  logic       parity_type;
  logic       tx, tx_done, fifo_empty, fifo_full;
  logic [7:0] overflow_cnt, parity_err_cnt;
  int         total = 0;
  int         bad   = 0;

  uart_echo_responder_if rx_if();

  uart_echo_responder #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
    .clk_3125       (clk_3125),
    .reset          (reset),
    .parity_type    (parity_type),
    .rx             (rx_if),
    .tx             (tx),
    .tx_done        (tx_done),
    .fifo_empty     (fifo_empty),
    .fifo_full      (fifo_full),
    .overflow_cnt   (overflow_cnt),
    .parity_err_cnt (parity_err_cnt)
  );

  always #5 clk_3125 = ~clk_3125;

  // Waits (bounded) for a start bit, then samples every bit mid-cell; no comparisons here.
  task automatic grab_frame(output logic [7:0] d, output logic p, output logic st,
                            output logic sp, output int done_at, output logic got);
    logic [10:0] bits;
    bits = '1; got = 1'b0; done_at = -1;
    for (int w = 0; w < 400 && !got; w++) begin
      @(negedge clk_3125);
      if (tx === 1'b0) got = 1'b1;
    end
    if (got) begin
      for (int c = 0; c < FRAME; c++) begin
        if (c != 0) @(negedge clk_3125);
        if (c % CPB == CPB / 2) bits[c / CPB] = tx;
        if (tx_done === 1'b1 && done_at < 0) done_at = c;
      end
    end
    st = bits[0]; d = bits[8:1]; p = bits[9]; sp = bits[10];
  endtask

  task automatic send_byte(input logic [7:0] b, input logic par);
    rx_if.rx_msg = b; rx_if.rx_parity = par; rx_if.rx_complete = 1'b1;
    @(negedge clk_3125);
    rx_if.rx_complete = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk_3125);
    total++; if (tx !== 1'b1) begin bad++; $display("FAIL reset_tx: got %b expected 1", tx); end
    total++; if (tx_done !== 1'b0) begin bad++; $display("FAIL reset_tx_done: got %b expected 0", tx_done); end
    total++; if (fifo_empty !== 1'b1) begin bad++; $display("FAIL reset_empty: got %b expected 1", fifo_empty); end
    total++; if (fifo_full !== 1'b0) begin bad++; $display("FAIL reset_full: got %b expected 0", fifo_full); end
    total++; if (overflow_cnt !== 8'd0) begin bad++; $display("FAIL reset_ovf: got %0d expected 0", overflow_cnt); end
    total++; if (parity_err_cnt !== 8'd0) begin bad++; $display("FAIL reset_perr: got %0d expected 0", parity_err_cnt); end
    reset = 1'b0;
    @(negedge clk_3125);
    total++; if (tx !== 1'b1) begin bad++; $display("FAIL idle_tx: got %b expected 1", tx); end
  endtask

  task automatic test_single_even();
    logic [10:0] exp_bits;
    int          tx_bad, done_bad;
    exp_bits = {1'b1, 1'b0, 8'h50, 1'b0};
    tx_bad = -1; done_bad = -1;
    parity_type = 1'b0;
    rx_if.rx_msg = 8'h50; rx_if.rx_parity = 1'b0; rx_if.rx_complete = 1'b1;
    @(negedge clk_3125);
    rx_if.rx_complete = 1'b0;
    total++; if (fifo_empty !== 1'b0) begin bad++; $display("FAIL single_push: empty got %b expected 0", fifo_empty); end
    total++; if (tx !== 1'b1) begin bad++; $display("FAIL single_early: tx got %b expected 1", tx); end
    for (int c = 0; c < FRAME; c++) begin
      @(negedge clk_3125);
      if (tx !== exp_bits[c / CPB] && tx_bad < 0) tx_bad = c;
      if (tx_done !== (c == FRAME - 1) && done_bad < 0) done_bad = c;
    end
    total++; if (tx_bad != -1) begin bad++; $display("FAIL single_wave: first wrong tx at frame cycle %0d expected none", tx_bad); end
    total++; if (done_bad != -1) begin bad++; $display("FAIL single_done: first wrong tx_done at frame cycle %0d expected none", done_bad); end
    @(negedge clk_3125);
    total++; if (tx !== 1'b1 || tx_done !== 1'b0) begin bad++; $display("FAIL single_after: tx/done got %b%b expected 10", tx, tx_done); end
    total++; if (fifo_empty !== 1'b1) begin bad++; $display("FAIL single_empty: got %b expected 1", fifo_empty); end
  endtask

  task automatic test_odd_parity();
    logic [7:0] d; logic p, st, sp, got; int done_at;
    parity_type = 1'b1;
    send_byte(8'h74, 1'b1);
    fork
      grab_frame(d, p, st, sp, done_at, got);
      begin repeat (40) @(negedge clk_3125); parity_type = 1'b0; end
    join
    total++; if (got !== 1'b1) begin bad++; $display("FAIL odd_start: got %b expected 1 (timeout)", got); end
    total++; if (d !== 8'h74) begin bad++; $display("FAIL odd_data: got %h expected 74", d); end
    total++; if (p !== 1'b1) begin bad++; $display("FAIL odd_parity: got %b expected 1", p); end
    total++; if (st !== 1'b0 || sp !== 1'b1) begin bad++; $display("FAIL odd_framing: start/stop got %b%b expected 01", st, sp); end
    total++; if (done_at != FRAME - 1) begin bad++; $display("FAIL odd_done: got %0d expected %0d", done_at, FRAME - 1); end
  endtask

  task automatic test_parity_error();
    parity_type = 1'b0;
    send_byte(8'h41, 1'b1);
`ifdef UART_ECHO_PARITY_CHECK_EN
    begin
      logic saw_low;
      saw_low = 1'b0;
      for (int i = 0; i < 400; i++) begin
        @(negedge clk_3125);
        if (tx !== 1'b1) saw_low = 1'b1;
      end
      total++; if (saw_low !== 1'b0) begin bad++; $display("FAIL perr_drop: tx low seen %b expected 0", saw_low); end
      total++; if (parity_err_cnt !== 8'd1) begin bad++; $display("FAIL perr_cnt: got %0d expected 1", parity_err_cnt); end
    end
`else
    begin
      logic [7:0] d; logic p, st, sp, got; int done_at;
      grab_frame(d, p, st, sp, done_at, got);
      total++; if (got !== 1'b1 || d !== 8'h41) begin bad++; $display("FAIL perr_echo: got %b/%h expected 1/41", got, d); end
      total++; if (p !== 1'b0) begin bad++; $display("FAIL perr_parity: got %b expected 0", p); end
      total++; if (parity_err_cnt !== 8'd0) begin bad++; $display("FAIL perr_cnt: got %0d expected 0", parity_err_cnt); end
    end
`endif
  endtask

  task automatic test_overflow();
    logic [7:0] d; logic p, st, sp, got; int done_at;
    logic [7:0] exp_seq [5];
    logic [7:0] b;
    logic       saw_low;
    exp_seq = '{8'h03, 8'h04, 8'h05, 8'h07, 8'h00};
    parity_type = 1'b0;
    fork
      begin
        for (int i = 1; i <= 6; i++) begin
          b = 8'(i);
          rx_if.rx_msg = b; rx_if.rx_parity = ^b; rx_if.rx_complete = 1'b1;
          @(negedge clk_3125);
          rx_if.rx_complete = 1'b0;
          @(negedge clk_3125);
        end
      end
      grab_frame(d, p, st, sp, done_at, got);
    join
    total++; if (got !== 1'b1 || d !== 8'h01 || p !== 1'b1) begin bad++; $display("FAIL ovf_frame1: got %b/%h/%b expected 1/01/1", got, d, p); end
    total++; if (fifo_full !== 1'b1) begin bad++; $display("FAIL ovf_full: got %b expected 1", fifo_full); end
    total++; if (overflow_cnt !== 8'd1) begin bad++; $display("FAIL ovf_cnt: got %0d expected 1", overflow_cnt); end
    // Next edge is STOP->IDLE; the one after pops while this byte pushes into a full FIFO.
    @(negedge clk_3125);
    rx_if.rx_msg = 8'h07; rx_if.rx_parity = 1'b1; rx_if.rx_complete = 1'b1;
    grab_frame(d, p, st, sp, done_at, got);
    rx_if.rx_complete = 1'b0;
    total++; if (got !== 1'b1 || d !== 8'h02 || p !== 1'b1) begin bad++; $display("FAIL ovf_frame2: got %b/%h/%b expected 1/02/1", got, d, p); end
    total++; if (fifo_full !== 1'b1) begin bad++; $display("FAIL ovf_pushpop_full: got %b expected 1", fifo_full); end
    total++; if (overflow_cnt !== 8'd1) begin bad++; $display("FAIL ovf_pushpop_cnt: got %0d expected 1", overflow_cnt); end
    for (int i = 0; i < 4; i++) begin
      grab_frame(d, p, st, sp, done_at, got);
      total++;
      if (got !== 1'b1 || d !== exp_seq[i] || p !== ^exp_seq[i] || done_at != FRAME - 1) begin
        bad++; $display("FAIL ovf_order%0d: got %b/%h/%b/%0d expected 1/%h/%b/%0d",
                        i, got, d, p, done_at, exp_seq[i], ^exp_seq[i], FRAME - 1);
      end
    end
    saw_low = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk_3125);
      if (tx !== 1'b1) saw_low = 1'b1;
    end
    total++; if (saw_low !== 1'b0) begin bad++; $display("FAIL ovf_no_extra: tx low seen %b expected 0", saw_low); end
    total++; if (fifo_empty !== 1'b1) begin bad++; $display("FAIL ovf_drained: got %b expected 1", fifo_empty); end
  endtask

  task automatic test_held_strobe();
    logic seen_done, saw_low;
    rx_if.rx_msg = 8'h3C; rx_if.rx_parity = 1'b0; rx_if.rx_complete = 1'b1;
    repeat (10) @(negedge clk_3125);
    rx_if.rx_complete = 1'b0;
    total++; if (tx !== 1'b0) begin bad++; $display("FAIL held_start: tx got %b expected 0", tx); end
    total++; if (fifo_empty !== 1'b1) begin bad++; $display("FAIL held_single: empty got %b expected 1", fifo_empty); end
    seen_done = 1'b0;
    for (int i = 0; i < 400 && !seen_done; i++) begin
      @(negedge clk_3125);
      if (tx_done === 1'b1) seen_done = 1'b1;
    end
    total++; if (seen_done !== 1'b1) begin bad++; $display("FAIL held_done: got %b expected 1 (timeout)", seen_done); end
    saw_low = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk_3125);
      if (tx !== 1'b1) saw_low = 1'b1;
    end
    total++; if (saw_low !== 1'b0) begin bad++; $display("FAIL held_no_second: tx low seen %b expected 0", saw_low); end
  endtask

  task automatic test_reset_mid_frame();
    logic saw_activity;
    send_byte(8'hA5, 1'b0);
    @(negedge clk_3125);
    send_byte(8'h11, 1'b0);
    @(negedge clk_3125);
    send_byte(8'h22, 1'b0);
    @(negedge clk_3125);
    // Now at frame cycle 4; cycle 120 lies inside data bit 3 (0xA5 bit 3 = 0).
    repeat (116) @(negedge clk_3125);
    total++; if (tx !== 1'b0) begin bad++; $display("FAIL rst_mid_bit3: tx got %b expected 0", tx); end
    total++; if (fifo_empty !== 1'b0) begin bad++; $display("FAIL rst_mid_queued: empty got %b expected 0", fifo_empty); end
    reset = 1'b1;
    @(negedge clk_3125);
    reset = 1'b0;
    total++; if (tx !== 1'b1 || tx_done !== 1'b0) begin bad++; $display("FAIL rst_mid_tx: tx/done got %b%b expected 10", tx, tx_done); end
    total++; if (fifo_empty !== 1'b1) begin bad++; $display("FAIL rst_mid_flush: empty got %b expected 1", fifo_empty); end
    total++; if (overflow_cnt !== 8'd0) begin bad++; $display("FAIL rst_mid_ovf: got %0d expected 0", overflow_cnt); end
    total++; if (parity_err_cnt !== 8'd0) begin bad++; $display("FAIL rst_mid_perr: got %0d expected 0", parity_err_cnt); end
    saw_activity = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk_3125);
      if (tx !== 1'b1 || tx_done !== 1'b0) saw_activity = 1'b1;
    end
    total++; if (saw_activity !== 1'b0) begin bad++; $display("FAIL rst_mid_quiet: activity %b expected 0", saw_activity); end
  endtask

  task automatic test_strobe_through_reset();
    logic [7:0] d; logic p, st, sp, got; int done_at;
    reset = 1'b1;
    rx_if.rx_msg = 8'h5A; rx_if.rx_parity = 1'b0; rx_if.rx_complete = 1'b1;
    repeat (3) @(negedge clk_3125);
    total++; if (fifo_empty !== 1'b1) begin bad++; $display("FAIL rstrobe_in_reset: empty got %b expected 1", fifo_empty); end
    reset = 1'b0;
    @(negedge clk_3125);
    total++; if (fifo_empty !== 1'b0) begin bad++; $display("FAIL rstrobe_capture: empty got %b expected 0", fifo_empty); end
    rx_if.rx_complete = 1'b0;
    grab_frame(d, p, st, sp, done_at, got);
    total++; if (got !== 1'b1 || d !== 8'h5A || p !== 1'b0) begin bad++; $display("FAIL rstrobe_echo: got %b/%h/%b expected 1/5a/0", got, d, p); end
  endtask

  initial begin
    reset = 1'b1;
    parity_type = 1'b0;
    rx_if.rx_msg = 8'h00; rx_if.rx_parity = 1'b0; rx_if.rx_complete = 1'b0;
    test_reset();
    test_single_even();
    test_odd_parity();
    test_parity_error();
    test_overflow();
    test_held_strobe();
    test_reset_mid_frame();
    test_strobe_through_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
